// File: rtl/striping_n.sv
// Parametrised round-robin word striper: spreads one DATA_W input stream across LANES output lanes,
// with packed mode, start-of-packet realignment to lane 0 and a saturating per-packet word counter.
module striping_n #(
    parameter int DATA_W    = 32,
    parameter int LANES     = 4,
    parameter int CNT_W     = 16,
    parameter int IDLE_ZERO = 1
) (
    input  logic                        clk_2f,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        valid_in,
    input  logic                        sop_in,
    input  logic                        mode,
    output logic [LANES*DATA_W-1:0]     lane_data,
    output logic [LANES-1:0]            lane_valid,
    output logic [$clog2(LANES)-1:0]    lane_sel,
    output logic                        group_done,
    output logic [CNT_W-1:0]            word_cnt
);

    localparam int SEL_W = $clog2(LANES);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);

    logic [SEL_W-1:0] wr_lane;
    logic [SEL_W-1:0] next_sel;

    // sop_in forces the write to lane 0 and outranks mode when choosing the next pointer;
    // LANES is a power of two, so the pointer wraps naturally in SEL_W bits.
    always_comb begin
        wr_lane  = sop_in ? '0 : lane_sel;
        next_sel = lane_sel;
        if (sop_in) begin
            next_sel = valid_in ? SEL_W'(1) : '0;
        end else if (valid_in || !mode) begin
            next_sel = lane_sel + SEL_W'(1);
        end
    end

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            lane_data  <= '0;
            lane_valid <= '0;
            lane_sel   <= '0;
            group_done <= 1'b0;
            word_cnt   <= '0;
        end else begin
            lane_sel   <= next_sel;
            group_done <= valid_in && (wr_lane == LAST_LANE);
            for (int k = 0; k < LANES; k++) begin
                if (valid_in && (wr_lane == SEL_W'(k))) begin
                    lane_data[k*DATA_W +: DATA_W] <= data_in;
                    lane_valid[k]                 <= 1'b1;
                end else begin
                    lane_valid[k] <= 1'b0;
                    if (IDLE_ZERO != 0) begin
                        lane_data[k*DATA_W +: DATA_W] <= '0;
                    end
                end
            end
            // Counter restarts on every sop_in and is left alone by idle cycles.
            if (sop_in) begin
                word_cnt <= valid_in ? CNT_W'(1) : '0;
            end else if (valid_in && (word_cnt != CNT_MAX)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_striping_n.sv
// Scoreboard bench for striping_n: directed vectors push hand-computed expectations,
// a monitor pops one entry per clock and compares every output of the main instance.
module tb_striping_n;

    logic         clk_2f;
    logic         reset;
    logic [31:0]  data_in;
    logic         valid_in;
    logic         sop_in;
    logic         mode;

    logic [127:0] lane_data;
    logic [3:0]   lane_valid;
    logic [1:0]   lane_sel;
    logic         group_done;
    logic [15:0]  word_cnt;

    logic [127:0] sat_lane_data;
    logic [3:0]   sat_lane_valid;
    logic [1:0]   sat_lane_sel;
    logic         sat_group_done;
    logic [2:0]   sat_word_cnt;

    logic [127:0] hold_lane_data;
    logic [3:0]   hold_lane_valid;
    logic [1:0]   hold_lane_sel;
    logic         hold_group_done;
    logic [15:0]  hold_word_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          lane;
        logic [31:0] data;
        logic [1:0]  sel;
        logic        gd;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    striping_n #(.DATA_W(32), .LANES(4), .CNT_W(16), .IDLE_ZERO(1)) dut (
        .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .sop_in(sop_in), .mode(mode), .lane_data(lane_data), .lane_valid(lane_valid),
        .lane_sel(lane_sel), .group_done(group_done), .word_cnt(word_cnt)
    );

    striping_n #(.DATA_W(32), .LANES(4), .CNT_W(3), .IDLE_ZERO(1)) dut_sat (
        .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .sop_in(sop_in), .mode(mode), .lane_data(sat_lane_data), .lane_valid(sat_lane_valid),
        .lane_sel(sat_lane_sel), .group_done(sat_group_done), .word_cnt(sat_word_cnt)
    );

    striping_n #(.DATA_W(32), .LANES(4), .CNT_W(16), .IDLE_ZERO(0)) dut_hold (
        .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .sop_in(sop_in), .mode(mode), .lane_data(hold_lane_data), .lane_valid(hold_lane_valid),
        .lane_sel(hold_lane_sel), .group_done(hold_group_done), .word_cnt(hold_word_cnt)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs on the falling edge and queue what the outputs must show after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic v, input logic sop, input logic m,
                                 input logic [31:0] d, input int lane, input logic [1:0] sel,
                                 input logic gd, input logic [15:0] cnt);
        exp_t e;
        @(negedge clk_2f);
        reset    = rst;
        valid_in = v;
        sop_in   = sop;
        mode     = m;
        data_in  = d;
        e.lane = lane;
        e.data = d;
        e.sel  = sel;
        e.gd   = gd;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    always @(posedge clk_2f) begin
        exp_t         e;
        logic [127:0] exp_data;
        logic [3:0]   exp_valid;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_data  = '0;
            exp_valid = '0;
            if (e.lane >= 0) begin
                exp_data[e.lane*32 +: 32] = e.data;
                exp_valid[e.lane]         = 1'b1;
            end
            checkOutput("lane_valid", {124'd0, lane_valid}, {124'd0, exp_valid});
            checkOutput("lane_data", lane_data, exp_data);
            checkOutput("lane_sel", {126'd0, lane_sel}, {126'd0, e.sel});
            checkOutput("group_done", {127'd0, group_done}, {127'd0, e.gd});
            checkOutput("word_cnt", {112'd0, word_cnt}, {112'd0, e.cnt});
        end
    end

    initial begin
        reset    = 1'b0;
        valid_in = 1'b0;
        sop_in   = 1'b0;
        mode     = 1'b1;
        data_in  = '0;

        // Reset held with valid traffic, then the first word lands on lane 0.
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFF, -1, 2'd0, 0, 16'd0);
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFF, -1, 2'd0, 0, 16'd0);
        applyStimulus(1, 1, 0, 1, 32'h0000_0011, 0, 2'd1, 0, 16'd1);

        // Packed streaming of eight words starting with sop.
        for (int i = 0; i < 8; i++)
            applyStimulus(1, 1, (i == 0), 1, 32'hA0 + 32'(i), i % 4, 2'((i + 1) % 4), (i % 4 == 3), 16'(i + 1));

        // Packed with gaps: pointer holds at 1 while idle.
        applyStimulus(1, 1, 1, 1, 32'hB0, 0, 2'd1, 0, 16'd1);
        applyStimulus(1, 0, 0, 1, 32'h0, -1, 2'd1, 0, 16'd1);
        applyStimulus(1, 0, 0, 1, 32'h0, -1, 2'd1, 0, 16'd1);
        applyStimulus(1, 1, 0, 1, 32'hB1, 1, 2'd2, 0, 16'd2);

        // Legacy toggle: idle slots consume lanes, pointer wraps on idle.
        applyStimulus(1, 1, 1, 0, 32'hC0, 0, 2'd1, 0, 16'd1);
        applyStimulus(1, 0, 0, 0, 32'h0, -1, 2'd2, 0, 16'd1);
        applyStimulus(1, 1, 0, 0, 32'hC1, 2, 2'd3, 0, 16'd2);
        applyStimulus(1, 0, 0, 0, 32'h0, -1, 2'd0, 0, 16'd2);
        applyStimulus(1, 1, 0, 0, 32'hC2, 0, 2'd1, 0, 16'd3);

        // Realignment to lane 0 from pointer 3, then sop alone in both modes.
        applyStimulus(1, 1, 1, 1, 32'hE0, 0, 2'd1, 0, 16'd1);
        applyStimulus(1, 1, 0, 1, 32'hE1, 1, 2'd2, 0, 16'd2);
        applyStimulus(1, 1, 0, 1, 32'hE2, 2, 2'd3, 0, 16'd3);
        applyStimulus(1, 1, 1, 1, 32'hD0, 0, 2'd1, 0, 16'd1);
        applyStimulus(1, 1, 0, 1, 32'hD1, 1, 2'd2, 0, 16'd2);
        applyStimulus(1, 0, 1, 1, 32'h0, -1, 2'd0, 0, 16'd0);
        applyStimulus(1, 1, 0, 1, 32'hD2, 0, 2'd1, 0, 16'd1);
        applyStimulus(1, 0, 1, 0, 32'h0, -1, 2'd0, 0, 16'd0);
        applyStimulus(1, 0, 0, 0, 32'h0, -1, 2'd1, 0, 16'd0);

        // Ten words: the 3-bit counter instance must saturate at 7.
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, (i == 0), 1, 32'hF0 + 32'(i), i % 4, 2'((i + 1) % 4), (i % 4 == 3), 16'(i + 1));
            if (i == 6 || i == 9) begin
                @(posedge clk_2f);
                #2;
                checkOutput("sat_word_cnt", {125'd0, sat_word_cnt}, 128'd7);
            end
        end

        // Mid-packet reset with valid traffic present.
        applyStimulus(0, 1, 0, 1, 32'hFFFF_FFFF, -1, 2'd0, 0, 16'd0);
        @(posedge clk_2f);
        #2;
        checkOutput("sat_reset_data", sat_lane_data, 128'd0);
        checkOutput("sat_reset_valid", {124'd0, sat_lane_valid}, 128'd0);
        checkOutput("sat_reset_sel", {126'd0, sat_lane_sel}, 128'd0);
        checkOutput("sat_reset_gd", {127'd0, sat_group_done}, 128'd0);
        checkOutput("sat_reset_cnt", {125'd0, sat_word_cnt}, 128'd0);
        checkOutput("hold_reset_data", hold_lane_data, 128'd0);
        checkOutput("hold_reset_valid", {124'd0, hold_lane_valid}, 128'd0);
        checkOutput("hold_reset_sel", {126'd0, hold_lane_sel}, 128'd0);
        checkOutput("hold_reset_gd", {127'd0, hold_group_done}, 128'd0);
        checkOutput("hold_reset_cnt", {112'd0, hold_word_cnt}, 128'd0);

        // Hold-mode instance keeps lane 2's last word once its valid drops.
        applyStimulus(1, 1, 1, 1, 32'h6A0, 0, 2'd1, 0, 16'd1);
        applyStimulus(1, 1, 0, 1, 32'h6A1, 1, 2'd2, 0, 16'd2);
        applyStimulus(1, 1, 0, 1, 32'h6A2, 2, 2'd3, 0, 16'd3);
        applyStimulus(1, 0, 0, 1, 32'h0, -1, 2'd3, 0, 16'd3);
        @(posedge clk_2f);
        #2;
        checkOutput("hold_lane2_data", {96'd0, hold_lane_data[64 +: 32]}, 128'h6A2);
        checkOutput("hold_lane2_valid", {127'd0, hold_lane_valid[2]}, 128'd0);
        applyStimulus(1, 0, 0, 1, 32'h0, -1, 2'd3, 0, 16'd3);

        for (int n = 0; n < 10 && sb.size() > 0; n++) @(posedge clk_2f);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/striping_n.md
Name: striping_n

Overview:
- Parametrised multi-lane byte-striping block; the successor to the fixed 2-lane striper.
- Distributes a single DATA_W-bit input word stream round-robin across LANES output lanes, one word per clk_2f cycle.
- Adds three things: a packed mode that skips idle cycles, start-of-packet realignment to lane 0, and a per-packet word counter.
- Sits between the input framer and the per-lane serialisers in the transmit path.

Parameters:
DATA_W, 32, width of the input word and of each lane.
LANES, 4, number of output lanes; power of two, 2 to 8.
CNT_W, 16, width of the saturating per-packet word counter.
IDLE_ZERO, 1, 1 = lane data register cleared to 0 when its valid is 0; 0 = lane data holds its last written word.

Ports:
clk_2f  input  1  single clock; all logic on rising edge.
reset  input  1  synchronous, active-low reset (0 = reset), sampled on clk_2f.
data_in  input  DATA_W  input word.
valid_in  input  1  data_in is valid this cycle.
sop_in  input  1  start of packet; meaningful with or without valid_in.
mode  input  1  0 = legacy toggle (pointer advances every cycle); 1 = packed (pointer advances only on valid_in).
lane_data  output  LANES*DATA_W  lane k occupies bits [k*DATA_W +: DATA_W].
lane_valid  output  LANES  lane_valid[k] = 1 when lane_data lane k carries a new word.
lane_sel  output  log2(LANES)  current round-robin pointer (next lane to be written).
group_done  output  1  1-cycle pulse when a word was written to lane LANES-1.
word_cnt  output  CNT_W  valid words accepted since the last sop_in; saturating.

Behaviour:
- Reset (reset == 0 at a clock edge): lane_data = 0, lane_valid = 0, lane_sel = 0, group_done = 0, word_cnt = 0. Reset overrides all other inputs and applies mid-packet with no residue.
- All outputs are registered. Latency is 1 cycle: a word sampled at edge n appears on its lane after edge n, with lane_valid[k] = 1 for exactly that cycle.
- Pointer p is held in lane_sel. A write to lane p happens when valid_in = 1.
- Pointer advance, mode 0: p <= (p + 1) mod LANES every cycle, valid or not. An idle cycle consumes a lane slot, so its lane_valid is 0 that cycle.
- Pointer advance, mode 1: p advances only on a write. Idle cycles leave p unchanged.
- At most one lane_valid bit is set in any cycle. All non-written lanes have lane_valid = 0 and, when IDLE_ZERO = 1, lane_data = 0. Outputs are never driven to Z.
- sop_in with valid_in = 1: the word goes to lane 0 regardless of p. Then p <= 1 mod LANES and word_cnt <= 1.
- sop_in with valid_in = 0: p <= 0 and word_cnt <= 0. No lane is written.
- sop_in has priority over mode in pointer update.
- word_cnt: +1 per write without sop_in, saturating at 2^CNT_W - 1. It is not cleared by idle cycles.
- group_done: registered, asserted in the same cycle as lane_valid[LANES-1].
- Wrap-around: p = LANES-1 wraps to 0.
- mode change takes effect at the next edge. The pointer is not reset on a mode change.
- The block has no backpressure; every valid_in is accepted.

Test Plan:
Use LANES = 4, DATA_W = 32, IDLE_ZERO = 1 unless stated.

1. Reset: hold reset = 0 for 2 cycles while valid_in = 1 and data_in = 0xFFFFFFFF -> all outputs 0. Release reset -> the first word lands on lane 0 the following cycle.
2. Packed streaming: mode = 1, sop with words 0xA0..0xA7 on consecutive cycles -> lanes 0,1,2,3,0,1,2,3. group_done pulses on the 4th and 8th output cycles. word_cnt = 8.
3. Packed with gaps: mode = 1, words 0xB0, idle, idle, 0xB1 -> 0xB1 appears on lane 1. lane_valid = 0 during the idle cycles. lane_sel is held at 1 while idle.
4. Legacy toggle: mode = 0, words 0xC0, idle, 0xC1 -> 0xC0 on lane 0, idle slot consumes lane 1, 0xC1 on lane 2.
5. Realignment: mode = 1, 3 words (pointer = 3), then sop_in with 0xD0 -> 0xD0 on lane 0, lane_sel = 1, word_cnt = 1. Separately, sop_in alone -> lane_sel = 0, word_cnt = 0, no lane_valid.
6. Saturation and mid-packet reset: CNT_W = 3, 10 words -> word_cnt stays at 7. Then assert reset mid-stream -> everything returns to 0 at the next edge. IDLE_ZERO = 0 run: lane 2 holds its last word while lane_valid[2] = 0.
